// File: rtl/logo_bounce_ctrl.sv
// Bouncing-logo position controller: moves a LOGO_W x LOGO_H sprite once per frame,
// reflects it off the active-area edges and maps the raster into logo-local ROM coords.
module logo_bounce_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int LOGO_W   = 128,
    parameter int LOGO_H   = 128,
    parameter int STEP     = 1,
    localparam int RX_W    = $clog2(LOGO_W),
    localparam int RY_W    = $clog2(LOGO_H)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [9:0]      pix_x,
    input  logic [9:0]      pix_y,
    input  logic            vsync,
    input  logic            pause,
    output logic [RX_W-1:0] rom_x,
    output logic [RY_W-1:0] rom_y,
    output logic            in_logo,
    output logic [2:0]      color_index,
    output logic [9:0]      pos_x,
    output logic [9:0]      pos_y,
    output logic            bounce
);

    localparam logic [10:0] MAX_X  = 11'(H_ACTIVE - LOGO_W);
    localparam logic [10:0] MAX_Y  = 11'(V_ACTIVE - LOGO_H);
    localparam logic [10:0] STEP_W = 11'(STEP);

    typedef struct packed {
        logic       hit;
        logic       dir_neg;
        logic [9:0] pos;
    } axis_t;

    // One axis of motion; comparisons are 11-bit so pos+STEP never wraps.
    function automatic axis_t step_axis(input logic [9:0] pos, input logic dir_neg,
                                        input logic [10:0] max);
        axis_t r;
        logic [10:0] p;
        p = {1'b0, pos};
        r.hit     = 1'b0;
        r.dir_neg = dir_neg;
        r.pos     = pos;
        if (!dir_neg) begin
            if (p + STEP_W >= max) begin
                r.pos     = max[9:0];
                r.dir_neg = 1'b1;
                r.hit     = 1'b1;
            end else begin
                r.pos = 10'(p + STEP_W);
            end
        end else begin
            if (p <= STEP_W) begin
                r.pos     = 10'd0;
                r.dir_neg = 1'b0;
                r.hit     = 1'b1;
            end else begin
                r.pos = 10'(p - STEP_W);
            end
        end
        return r;
    endfunction

    logic [9:0] pos_x_q, pos_y_q;
    logic       dir_x_neg_q, dir_y_neg_q;
    logic       vsync_q;
    logic [2:0] color_q, color_d;
    logic       bounce_q;
    logic       tick;
    axis_t      ax_d, ay_d;

    always_comb begin
        tick    = vsync & ~vsync_q;
        ax_d    = step_axis(pos_x_q, dir_x_neg_q, MAX_X);
        ay_d    = step_axis(pos_y_q, dir_y_neg_q, MAX_Y);
        color_d = (color_q == 3'd7) ? 3'd1 : color_q + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_x_q     <= 10'd0;
            pos_y_q     <= 10'd0;
            dir_x_neg_q <= 1'b0;
            dir_y_neg_q <= 1'b0;
            vsync_q     <= 1'b0;
            color_q     <= 3'd1;
            bounce_q    <= 1'b0;
        end else begin
            vsync_q  <= vsync;
            bounce_q <= 1'b0;
            // A paused tick is dropped, not deferred to the next frame.
            if (tick && !pause) begin
                pos_x_q     <= ax_d.pos;
                pos_y_q     <= ay_d.pos;
                dir_x_neg_q <= ax_d.dir_neg;
                dir_y_neg_q <= ay_d.dir_neg;
                bounce_q    <= ax_d.hit | ay_d.hit;
                if (ax_d.hit || ay_d.hit) begin
                    color_q <= color_d;
                end
            end
        end
    end

    // Zero-latency raster mapping so it stays aligned with pix_x/pix_y.
    always_comb begin
        in_logo = ({1'b0, pix_x} >= {1'b0, pos_x_q}) &&
                  ({1'b0, pix_x} <  {1'b0, pos_x_q} + 11'(LOGO_W)) &&
                  ({1'b0, pix_y} >= {1'b0, pos_y_q}) &&
                  ({1'b0, pix_y} <  {1'b0, pos_y_q} + 11'(LOGO_H));
        rom_x   = RX_W'(pix_x - pos_x_q);
        rom_y   = RY_W'(pix_y - pos_y_q);
    end

    assign color_index = color_q;
    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign bounce      = bounce_q;

endmodule

// File: tb/tb_logo_bounce_ctrl.sv
// Directed bench for logo_bounce_ctrl: a 640x480 STEP=1 instance and a square
// 640x640 STEP=4 instance whose axes reach both walls on the same frame.
module tb_logo_bounce_ctrl;

    logic       clk;
    logic       rst_n;
    logic [9:0] pix_x, pix_y;
    logic       vsync, pause, vsync_c, pause_c;

    logic [6:0] rom_x, rom_y, rom_x_c, rom_y_c;
    logic       in_logo, in_logo_c;
    logic [2:0] color, color_c;
    logic [9:0] pos_x, pos_y, pos_x_c, pos_y_c;
    logic       bnc, bnc_c;

    int n_checks = 0;
    int n_err    = 0;
    logic b1, b2;

    logo_bounce_ctrl #(.H_ACTIVE(640), .V_ACTIVE(480), .LOGO_W(128), .LOGO_H(128), .STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .vsync(vsync), .pause(pause),
        .rom_x(rom_x), .rom_y(rom_y), .in_logo(in_logo), .color_index(color),
        .pos_x(pos_x), .pos_y(pos_y), .bounce(bnc)
    );

    logo_bounce_ctrl #(.H_ACTIVE(640), .V_ACTIVE(640), .LOGO_W(128), .LOGO_H(128), .STEP(4)) dutc (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .vsync(vsync_c), .pause(pause_c),
        .rom_x(rom_x_c), .rom_y(rom_y_c), .in_logo(in_logo_c), .color_index(color_c),
        .pos_x(pos_x_c), .pos_y(pos_y_c), .bounce(bnc_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One vsync pulse of 'hi' cycles; b1 = bounce right after the update edge, b2 = one cycle later.
    task automatic do_tick(input bit sel, input int hi);
        @(negedge clk);
        if (sel) vsync_c = 1'b1; else vsync = 1'b1;
        @(negedge clk);
        b1 = sel ? bnc_c : bnc;
        @(negedge clk);
        b2 = sel ? bnc_c : bnc;
        repeat (hi) @(negedge clk);
        if (sel) vsync_c = 1'b0; else vsync = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input bit sel, input int n);
        for (int i = 0; i < n; i++) do_tick(sel, 0);
    endtask

    task automatic set_pix(input int x, input int y);
        @(negedge clk);
        pix_x = 10'(x);
        pix_y = 10'(y);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; vsync = 1'b0; pause = 1'b0; vsync_c = 1'b0; pause_c = 1'b0;
        pix_x = 10'd0; pix_y = 10'd0;
        repeat (3) @(negedge clk);
        check("rst_pos_x", pos_x, 0);
        check("rst_pos_y", pos_y, 0);
        check("rst_color", color, 1);
        check("rst_bounce", bnc, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Ten frames from reset, no walls reached.
        ticks(0, 10);
        check("t1_pos_x", pos_x, 10);
        check("t1_pos_y", pos_y, 10);
        check("t1_color", color, 1);
        check("t1_bounce", b1, 0);

        // Long vsync still yields a single update.
        do_tick(0, 20);
        check("long_vs_x", pos_x, 11);
        check("long_vs_y", pos_y, 11);

        // Bottom wall (MAX_Y=352) on frame 352.
        ticks(0, 340);
        check("pre_y_pos_y", pos_y, 351);
        do_tick(0, 0);
        check("ybnc_pos_y", pos_y, 352);
        check("ybnc_pos_x", pos_x, 352);
        check("ybnc_pulse", b1, 1);
        check("ybnc_pulse_end", b2, 0);
        check("ybnc_color", color, 2);

        // Right wall (MAX_X=512) on frame 512; y is heading back up.
        ticks(0, 159);
        check("pre_x_pos_x", pos_x, 511);
        check("pre_x_pos_y", pos_y, 193);
        check("pre_x_color", color, 2);
        do_tick(0, 0);
        check("xbnc_pos_x", pos_x, 512);
        check("xbnc_pos_y", pos_y, 192);
        check("xbnc_pulse", b1, 1);
        check("xbnc_pulse_end", b2, 0);
        check("xbnc_color", color, 3);
        do_tick(0, 0);
        check("post_x_pos_x", pos_x, 511);
        check("post_x_pos_y", pos_y, 191);
        check("post_x_bounce", b1, 0);
        check("post_x_color", color, 3);

        // Pause across three frames, then resume.
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_tick(0, 0);
            check("pause_bounce", b1, 0);
        end
        check("pause_pos_x", pos_x, 511);
        check("pause_pos_y", pos_y, 191);
        check("pause_color", color, 3);
        pause = 1'b0;
        do_tick(0, 0);
        check("resume_pos_x", pos_x, 510);
        check("resume_pos_y", pos_y, 190);
        check("resume_color", color, 3);

        // Raster mapping with logo at (510,190).
        set_pix(510, 190);
        check("map_tl_in", in_logo, 1);
        check("map_tl_rx", rom_x, 0);
        check("map_tl_ry", rom_y, 0);
        set_pix(637, 317);
        check("map_br_in", in_logo, 1);
        check("map_br_rx", rom_x, 127);
        check("map_br_ry", rom_y, 127);
        set_pix(600, 250);
        check("map_mid_rx", rom_x, 90);
        check("map_mid_ry", rom_y, 60);
        set_pix(638, 190);
        check("map_right_out", in_logo, 0);
        set_pix(509, 190);
        check("map_left_out", in_logo, 0);
        set_pix(510, 318);
        check("map_below_out", in_logo, 0);
        set_pix(510, 189);
        check("map_above_out", in_logo, 0);

        // Square instance: corner hit on frame 128 gives one pulse and one increment.
        ticks(1, 127);
        check("c_pre_x", pos_x_c, 508);
        check("c_pre_color", color_c, 1);
        do_tick(1, 0);
        check("corner_x", pos_x_c, 512);
        check("corner_y", pos_y_c, 512);
        check("corner_pulse", b1, 1);
        check("corner_pulse_end", b2, 0);
        check("corner_color", color_c, 2);
        ticks(1, 640);
        check("c768_x", pos_x_c, 0);
        check("c768_y", pos_y_c, 0);
        check("c768_color", color_c, 7);
        ticks(1, 127);
        do_tick(1, 0);
        check("wrap_x", pos_x_c, 512);
        check("wrap_pulse", b1, 1);
        check("wrap_color", color_c, 1);

        // Mid-frame reset takes effect on the next edge.
        @(negedge clk);
        rst_n = 1'b0;
        vsync = 1'b1;
        @(negedge clk);
        check("midrst_pos_x", pos_x, 0);
        check("midrst_pos_y", pos_y, 0);
        check("midrst_color", color, 1);
        check("midrst_c_x", pos_x_c, 0);

        // vsync already high when reset releases: exactly one update.
        rst_n = 1'b1;
        @(negedge clk);
        check("stuck_first_x", pos_x, 1);
        check("stuck_first_y", pos_y, 1);
        repeat (20) @(negedge clk);
        check("stuck_hold_x", pos_x, 1);
        check("stuck_hold_y", pos_y, 1);
        vsync = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
